mesh_input_port: RTL
====================

MESH_INPUT_PORT -- requirements
Module: mesh_input_port

Interface
REQ-001 Parameter WIDTH, default 64, flit width in bits; SHALL be at least 56.
REQ-002 Parameter DEPTH, default 2, FIFO entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 di  input  WIDTH  flit arriving from the upstream mesh_link do.
REQ-006 si  input  1  upstream flit valid, driven from mesh_link so.
REQ-007 ri  output  1  ready to accept a flit; drives mesh_link ro.
REQ-008 do  output  WIDTH  head flit with its hop field already updated.
REQ-009 so  output  1  head flit valid.
REQ-010 ro  input  1  downstream (crossbar/arbiter) ready.
REQ-011 route  output  5  one-hot output port for the head flit: [0] E, [1] W, [2] N, [3] S, [4] LOCAL.

Function
REQ-012 Flit fields: [62] x-dir (0=E, 1=W); [61] y-dir (0=N, 1=S); [55:52] hop_x; [51:48] hop_y. All other bits SHALL pass through unchanged.
REQ-013 A push occurs on a clk edge where si=1 and ri=1; a pop occurs on a clk edge where so=1 and ro=1.
REQ-014 ri SHALL be 1 exactly when the stored count is less than DEPTH, with no combinational path from ro or si.
REQ-015 When full, a simultaneous pop SHALL NOT allow a push in the same cycle; ri rises the cycle after the pop.
REQ-016 so SHALL be 1 exactly when the count is nonzero; there is no bypass, so minimum latency from push to so is 1 cycle.
REQ-017 Route compute is combinational on the head entry:
- hop_x != 0: route = E or W from x-dir, and hop_x is decremented by 1 in do.
- otherwise hop_y != 0: route = N or S from y-dir, and hop_y is decremented by 1 in do.
- otherwise: route = LOCAL and do equals the head flit unmodified.
REQ-018 route SHALL be 5'b00000 whenever so=0; do is don't-care whenever so=0.
REQ-019 Flits SHALL leave in arrival order; the read and write pointers wrap modulo DEPTH.
REQ-020 Count SHALL be log2(DEPTH)+1 bits wide; on a simultaneous push and pop it SHALL stay unchanged.
REQ-021 A push when ri=0, or a pop when so=0, SHALL be ignored without corrupting state.
REQ-022 do, route and so SHALL be stable while so=1 and ro=0.

Reset
REQ-023 While reset=0: pointers and count = 0, ri=0, so=0, route=0; storage contents are not reset.
REQ-024 ri SHALL rise on the first clk edge after reset deasserts.
REQ-025 Reset asserted mid-stream SHALL drop all stored flits immediately, without waiting for a clock.

Structure
REQ-026 Shared package mesh_pkg SHALL hold:
- field bit positions (VC, x-dir, y-dir, hop_x, hop_y);
- port-index constants E/W/N/S/LOCAL;
- NUM_PORTS = 5.
REQ-027 Storage and pointers SHALL be in sub-module mesh_fifo (WIDTH, DEPTH); route compute and hop decrement stay in mesh_input_port.

Verification
REQ-028 Reset: hold reset=0 for 3 cycles, then release -> ri=0, so=0, route=0 during reset; ri=1 on the first edge after release.
REQ-029 X hop: push a flit with hop_x=3, x-dir=1, hop_y=2, ro=1 -> next cycle so=1, route=5'b00010, do[55:52]=2, do[51:48]=2.
REQ-030 Y and local hops:
- push hop_x=0, hop_y=1, y-dir=0 -> route=5'b00100, do[51:48]=0;
- push hop_x=0, hop_y=0 -> route=5'b10000, do==di.
REQ-031 Backpressure: with ro=0, push 0xA, 0xB -> ri=0 after the 2nd push and a 3rd si is ignored; release ro -> 0xA then 0xB on consecutive cycles, and ri=1 one cycle after the first pop.
REQ-032 Streaming: si=1 and ro=1 for 16 cycles with incrementing payloads -> 15 flits out, in order and none lost, with count never exceeding 1.
REQ-033 Mid-stream reset: assert reset=0 with 2 flits stored -> so=0 immediately; after release no stale flit appears.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh router definitions: flit field positions and output port indices.
package mesh_pkg;

    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned VC_BIT    = 63;
    localparam int unsigned X_DIR_BIT = 62;
    localparam int unsigned Y_DIR_BIT = 61;
    localparam int unsigned HOP_X_LSB = 52;
    localparam int unsigned HOP_Y_LSB = 48;
    localparam int unsigned HOP_W     = 4;

    typedef enum logic [2:0] {
        PORT_E     = 3'd0,
        PORT_W     = 3'd1,
        PORT_N     = 3'd2,
        PORT_S     = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
        return NUM_PORTS'(1) << p;
    endfunction

endpackage

// File: rtl/mesh_fifo.sv
// Input-port flit FIFO: unreset storage, wrapping pointers and an occupancy count.
module mesh_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mesh_input_port.sv
// Mesh router input port: buffers upstream flits and computes XY route and hop update for the head flit.
module mesh_input_port
    import mesh_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     di,
    input  logic                 si,
    output logic                 ri,
    output logic [WIDTH-1:0]     dout,
    output logic                 so,
    input  logic                 ro,
    output logic [NUM_PORTS-1:0] route
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned EXT_W = (WIDTH > 64) ? WIDTH : 64;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             accept_en;
    logic             push;
    logic             pop;
    logic [EXT_W-1:0] head_ext;
    logic [EXT_W-1:0] out_ext;
    logic [HOP_W-1:0] hop_x;
    logic [HOP_W-1:0] hop_y;

    // Holds ri low through reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) accept_en <= 1'b0;
        else        accept_en <= 1'b1;
    end

    assign ri   = accept_en && (count < CW'(DEPTH));
    assign so   = (count != '0);
    assign push = si && ri;
    assign pop  = so && ro;

    mesh_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (di),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Widened copy keeps the fixed field positions in range for any legal WIDTH.
    always_comb begin
        head_ext = EXT_W'(head);
        out_ext  = head_ext;
        hop_x    = head_ext[HOP_X_LSB +: HOP_W];
        hop_y    = head_ext[HOP_Y_LSB +: HOP_W];
        route    = '0;
        if (so) begin
            if (hop_x != '0) begin
                out_ext[HOP_X_LSB +: HOP_W] = hop_x - 1'b1;
                route = port_onehot(head_ext[X_DIR_BIT] ? PORT_W : PORT_E);
            end else if (hop_y != '0) begin
                out_ext[HOP_Y_LSB +: HOP_W] = hop_y - 1'b1;
                route = port_onehot(head_ext[Y_DIR_BIT] ? PORT_S : PORT_N);
            end else begin
                route = port_onehot(PORT_LOCAL);
            end
        end
    end

    assign dout = out_ext[WIDTH-1:0];

endmodule
